apb_master_arb: RTL and testbench

Multi-requester APB master. Accepts single-beat read/write requests from `NUM_REQ` internal requesters and arbitrates between them round-robin. Drives the shared APB bus through the SETUP and ACCESS phases, with an optional PREADY timeout. Returns PRDATA/PSLVERR to the granted requester. Sits between the internal command sources and the `apb_if` master modport.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_if.sv | 29 ++
 rtl/apb_rr_arbiter.sv | 32 +++
 rtl/apb_master_arb.sv | 135 +++++++++++++
 tb/tb_apb_master_arb.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and widths for the APB master arbiter
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef logic [2:0] apb_prot_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB bus signal bundle with master and slave views
interface apb_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);
  import apb_pkg::*;

  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  apb_prot_t           PPROT;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin pick starting after ptr
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan requesters in order ptr+1, ptr+2, ... and take the first one pending.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - round-robin multi-requester APB master
module apb_master_arb #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = apb_pkg::APB_ADDR_W,
  parameter int DATA_W      = apb_pkg::APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  input  logic [NUM_REQ*3-1:0]      req_prot,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  apb_if.master                     apb
);
  import apb_pkg::*;

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // A zero timeout still needs a one-bit counter to keep the logic well formed.
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  apb_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    cur;
  logic [CNT_W-1:0]    cnt;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic                accept;
  logic                timeout_hit;

  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_strb;
  apb_prot_t           sel_prot;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  ((state == IDLE) && PRESET),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready   = gnt;
  assign accept      = |gnt;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

  // Winner's fields, muxed straight from the flattened request buses.
  assign sel_write = req_write[gnt_idx];
  assign sel_addr  = req_addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(gnt_idx) * DATA_W +: DATA_W];
  assign sel_strb  = sel_write ? req_strb[int'(gnt_idx) * STRB_W +: STRB_W] : '0;
  assign sel_prot  = req_prot[int'(gnt_idx) * 3 +: 3];

  // Transfer FSM: bus outputs and responses are all registered here.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      cur         <= '0;
      cnt         <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PSTRB   <= '0;
      apb.PPROT   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= sel_write;
            apb.PADDR   <= sel_addr;
            apb.PWDATA  <= sel_wdata;
            apb.PSTRB   <= sel_strb;
            apb.PPROT   <= sel_prot;
            cur         <= gnt_idx;
            ptr         <= gnt_idx;
            state       <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
            rsp_err     <= apb.PSLVERR;
            rsp_valid   <= NUM_REQ'(1) << cur;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= NUM_REQ'(1) << cur;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// tb/tb_apb_master_arb.sv - self-checking bench for apb_master_arb
module tb_apb_master_arb;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 4;

  logic PCLK = 1'b0;
  logic PRESET = 1'b0;
  always #5 PCLK = ~PCLK;

  logic [N-1:0]    req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*SW-1:0] req_strb = '0;
  logic [N*3-1:0]  req_prot = '0;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  apb_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_master_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(apb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [109:0] all_outs();
    return {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB,
            apb.PPROT, rsp_valid, rsp_rdata, rsp_err};
  endfunction

  task automatic set_req(input int i, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW]  = s;
    req_prot[i*3 +: 3]    = p;
  endtask

  task automatic test_reset();
    req_valid = '1;
    @(negedge PCLK); @(negedge PCLK);
    n_tests++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready);
    end
    req_valid = '0;
    PRESET = 1'b1;
    @(negedge PCLK);
    n_tests++;
    if ({apb.PSEL, apb.PENABLE, rsp_valid} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0", {apb.PSEL, apb.PENABLE, rsp_valid});
    end
  endtask

  task automatic test_single_write();
    @(negedge PCLK);
    set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL wr_ready: got %b expected 001", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    n_tests++;
    if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT} !==
        {1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010}) begin
      n_fail++; $display("FAIL wr_setup: got %b/%b/%b %h %h %h %b", apb.PSEL, apb.PENABLE,
                         apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT);
    end
    @(negedge PCLK);
    n_tests++;
    if ({apb.PSEL, apb.PENABLE} !== 2'b11) begin
      n_fail++; $display("FAIL wr_access: got %b expected 11", {apb.PSEL, apb.PENABLE});
    end
    @(negedge PCLK);
    n_tests++;
    if ({rsp_valid, rsp_err, apb.PSEL} !== {3'b001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL wr_rsp: got %b expected 00100", {rsp_valid, rsp_err, apb.PSEL});
    end
  endtask

  task automatic test_read_wait();
    @(negedge PCLK);
    set_req(1, 1'b0, 32'h20, 32'h55, 4'hF, 3'b000);
    apb.PREADY = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL rd_ready: got %b expected 010", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    n_tests++;
    if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PSTRB} !== {3'b100, 4'h0}) begin
      n_fail++; $display("FAIL rd_setup: got %b expected 1000000", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PSTRB});
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge PCLK);
      n_tests++;
      if ({apb.PSEL, apb.PENABLE, apb.PADDR} !== {2'b11, 32'h20}) begin
        n_fail++; $display("FAIL rd_wait%0d: got %b %h expected 11 20", j, {apb.PSEL, apb.PENABLE}, apb.PADDR);
      end
      apb.PREADY = (j == 3);
      apb.PRDATA = (j == 3) ? 32'h12345678 : $urandom;
    end
    @(negedge PCLK);
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 1'b0, 32'h12345678}) begin
      n_fail++; $display("FAIL rd_rsp: got %b %b %h expected 010 0 12345678", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_round_robin();
    int exp_o[4] = '{0, 1, 0, 1};
    int got = 0;
    int last = 0;
    apb.PREADY = 1'b1;
    @(negedge PCLK);
    set_req(0, 1'b1, 32'h100, 32'h1, 4'h1, 3'b000);
    set_req(1, 1'b0, 32'h104, 32'h2, 4'h2, 3'b001);
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (c > 0) @(negedge PCLK);
      #1;
      if (req_ready !== '0) begin
        n_tests++;
        if (req_ready !== N'(1 << exp_o[got]) || apb.PSEL !== 1'b0) begin
          n_fail++; $display("FAIL rr_grant%0d: got %b psel %b expected %b psel 0", got, req_ready, apb.PSEL, N'(1 << exp_o[got]));
        end
        if (got > 0) begin
          n_tests++;
          if (c - last !== 3) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d expected 3", got, c - last); end
        end
        last = c;
        got++;
      end else begin
        n_tests++;
        if (apb.PSEL !== 1'b1) begin n_fail++; $display("FAIL rr_busy: got psel %b expected 1", apb.PSEL); end
      end
    end
    n_tests++;
    if (got !== 4) begin n_fail++; $display("FAIL rr_count: got %0d grants expected 4", got); end
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK); @(negedge PCLK);
    n_tests++;
    if ({rsp_valid, rsp_err} !== {3'b010, 1'b0}) begin
      n_fail++; $display("FAIL rr_last_rsp: got %b expected 0100", {rsp_valid, rsp_err});
    end
  endtask

  task automatic test_slave_error();
    @(negedge PCLK);
    set_req(2, 1'b1, 32'h30, 32'hCAFE, 4'h3, 3'b100);
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 3'b100) begin n_fail++; $display("FAIL err_ready: got %b expected 100", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK); @(negedge PCLK);
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b100, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL err_rsp: got %b %b %h expected 100 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    apb.PSLVERR = 1'b0;
  endtask

  task automatic test_timeout();
    @(negedge PCLK);
    set_req(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b000);
    apb.PREADY = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL to_ready: got %b expected 001", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    for (int j = 0; j < T; j++) begin
      @(negedge PCLK);
      apb.PRDATA = $urandom;
      n_tests++;
      if ({apb.PSEL, apb.PENABLE, rsp_valid} !== {2'b11, 3'b000}) begin
        n_fail++; $display("FAIL to_access%0d: got %b expected 11000", j, {apb.PSEL, apb.PENABLE, rsp_valid});
      end
    end
    @(negedge PCLK);
    n_tests++;
    if ({rsp_valid, rsp_err, rsp_rdata, apb.PSEL, apb.PENABLE} !== {3'b001, 1'b1, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL to_rsp: got %b %b %h psel %b", rsp_valid, rsp_err, rsp_rdata, apb.PSEL);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge PCLK);
    set_req(1, 1'b1, 32'h50, 32'hA5A5A5A5, 4'h3, 3'b111);
    apb.PREADY = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin n_fail++; $display("FAIL mr_ready: got %b expected 010", req_ready); end
    @(negedge PCLK); @(negedge PCLK);
    #2 PRESET = 1'b0;
    #1;
    n_tests++;
    if (all_outs() !== '0 || req_ready !== '0) begin
      n_fail++; $display("FAIL mr_outs: got %h ready %b expected 0", all_outs(), req_ready);
    end
    @(negedge PCLK); @(negedge PCLK);
    PRESET = 1'b1; req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge PCLK);
      n_tests++;
      if (rsp_valid !== '0) begin n_fail++; $display("FAIL mr_no_rsp: got %b expected 000", rsp_valid); end
    end
    set_req(0, 1'b0, 32'h60, 32'h0, 4'h0, 3'b000);
    set_req(1, 1'b0, 32'h64, 32'h0, 4'h0, 3'b000);
    apb.PREADY = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mr_first: got %b expected 001", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK); @(negedge PCLK);
    n_tests++;
    if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL mr_rsp: got %b expected 001", rsp_valid); end
  endtask

  // Transaction-level model: round-robin pick, fixed 3+A cycle shape, timeout rule.
  task automatic test_random();
    int ptr_m = N - 1;
    bit inflight = 0;
    int t_acc = 0, cur = 0, w = 0, acc_n = 1, k;
    bit e_err = 0, l_err = 0, s_err = 0;
    logic [31:0] e_rdata = '0, l_rdata = '0, s_data = '0;
    logic [72:0] e_fields = '0;
    @(negedge PCLK);
    PRESET = 1'b0; req_valid = '0;
    @(negedge PCLK);
    PRESET = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge PCLK);
      k = cyc - t_acc;
      if (inflight && k == 2 + acc_n) begin
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {N'(1 << cur), e_err, e_rdata}) begin
          n_fail++; $display("FAIL rnd_rsp@%0d: got %b %b %h expected %b %b %h", cyc, rsp_valid,
                             rsp_err, rsp_rdata, N'(1 << cur), e_err, e_rdata);
        end
        inflight = 0; l_err = e_err; l_rdata = e_rdata;
      end else begin
        n_tests++;
        if (rsp_valid !== '0 || {rsp_err, rsp_rdata} !== {l_err, l_rdata}) begin
          n_fail++; $display("FAIL rnd_rsp_hold@%0d: got %b %b %h expected 0 %b %h", cyc, rsp_valid,
                             rsp_err, rsp_rdata, l_err, l_rdata);
        end
      end
      n_tests++;
      if ({apb.PSEL, apb.PENABLE} !== {inflight, inflight && k >= 2} ||
          {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT} !== e_fields) begin
        n_fail++; $display("FAIL rnd_bus@%0d: got %b%b %h expected %b%b %h", cyc, apb.PSEL, apb.PENABLE,
                           {apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT}, inflight,
                           inflight && k >= 2, e_fields);
      end
      if (inflight && k == 1) begin
        req_valid[cur] = 1'b0;
        req_addr[cur*AW +: AW] = $urandom;
        req_wdata[cur*DW +: DW] = $urandom;
      end
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom));
      if (inflight && k >= 2) begin
        apb.PREADY  = (k - 2 == w);
        apb.PRDATA  = (k - 2 == w) ? s_data : $urandom;
        apb.PSLVERR = (k - 2 == w) ? s_err : 1'($urandom);
      end else begin
        apb.PREADY = 1'($urandom); apb.PRDATA = $urandom; apb.PSLVERR = 1'($urandom);
      end
      #1;
      if (!inflight) begin
        int win = -1;
        for (int j = 1; j <= N; j++)
          if (win < 0 && req_valid[(ptr_m + j) % N]) win = (ptr_m + j) % N;
        n_tests++;
        if (req_ready !== ((win < 0) ? N'(0) : N'(1 << win))) begin
          n_fail++; $display("FAIL rnd_grant@%0d: got %b expected winner %0d", cyc, req_ready, win);
        end
        if (win >= 0) begin
          inflight = 1; t_acc = cyc; cur = win; ptr_m = win;
          e_fields = {req_write[win], req_addr[win*AW +: AW], req_wdata[win*DW +: DW],
                      req_write[win] ? req_strb[win*SW +: SW] : 4'h0, req_prot[win*3 +: 3]};
          w = $urandom_range(0, 6); s_err = 1'($urandom); s_data = $urandom;
          acc_n = (w >= T) ? T : w + 1;
          e_err   = (w >= T) ? 1'b1 : s_err;
          e_rdata = (w >= T || req_write[win]) ? 32'h0 : s_data;
        end
      end else begin
        n_tests++;
        if (req_ready !== '0) begin n_fail++; $display("FAIL rnd_busy_ready@%0d: got %b expected 000", cyc, req_ready); end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_slave_error();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
